// File: rtl/npc_pkg.sv
// Shared NPC core constants: register file geometry defaults and the
// writeback-select bit positions used by the wb_load/wb_pc/wb_alu mux.
package npc_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 64;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    localparam int WB_LOAD = 0;
    localparam int WB_PC   = 1;
    localparam int WB_ALU  = 2;
    localparam int WB_NSRC = 3;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with a live count of outstanding writes.
// Writeback clears first, then issue sets, so a re-claim of the same register wins.
module rf_scoreboard
    import npc_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    input  logic              wb_en_i,
    input  logic [AW-1:0]     wb_addr_i,
    output logic [2**AW-1:0]  busy_o,
    output logic [AW:0]       busy_cnt_o
);

    logic [2**AW-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             iss_set, set_eff, clr_eff;

    assign iss_set = iss_en_i && (iss_addr_i != AW'(REG_ZERO));

    // Only the wb and iss addresses can change, so the count moves by at most
    // one in each direction; a clear that is immediately re-set is a no-op.
    assign set_eff = iss_set && !busy_q[iss_addr_i];
    assign clr_eff = wb_en_i && busy_q[wb_addr_i]
                     && !(iss_set && (iss_addr_i == wb_addr_i));

    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d = cnt_q + (AW+1)'(set_eff) - (AW+1)'(clr_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Pipelined-core GPR file: NRD combinational read ports, one writeback port with
// a 3-source AND-OR select, and a busy scoreboard. Macro RF_BYPASS_EN adds wb->read bypass.
module regfile_sb
    import npc_pkg::*;
#(
    parameter int DW  = XLEN,
    parameter int AW  = REG_AW,
    parameter int NRD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wb_en,
    input  logic              wb_load,
    input  logic              wb_pc,
    input  logic              wb_alu,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DW-1:0]     load_data,
    input  logic [DW-1:0]     pc_data,
    input  logic [DW-1:0]     alu_data,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    output logic [AW:0]       busy_cnt
);

    logic [DW-1:0]      gpr_q [2**AW];
    logic [WB_NSRC-1:0] wb_sel;
    logic [DW-1:0]      wb_data;
    logic [2**AW-1:0]   busy;

    assign wb_sel = {wb_alu, wb_pc, wb_load};
    assign wb_data = ({DW{wb_sel[WB_LOAD]}} & load_data)
                   | ({DW{wb_sel[WB_PC]}}   & pc_data)
                   | ({DW{wb_sel[WB_ALU]}}  & alu_data);

    // Storage must clear on reset, so it is a flop array rather than block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
            gpr_q[wb_addr] <= wb_data;
        end
    end

    rf_scoreboard #(.AW(AW)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt)
    );

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic [DW-1:0] stored;

            assign addr   = rd_addr[gi*AW +: AW];
            assign stored = (addr == AW'(REG_ZERO)) ? '0 : gpr_q[addr];

`ifdef RF_BYPASS_EN
            logic hit;
            assign hit = wb_en && (wb_addr != AW'(REG_ZERO)) && (addr == wb_addr);
            assign rd_data[gi*DW +: DW] = hit ? wb_data : stored;
            // A same-cycle re-claim keeps the operand busy for the new producer.
            assign rd_busy[gi] = hit ? (iss_en && (iss_addr == wb_addr)) : busy[addr];
`else
            assign rd_data[gi*DW +: DW] = stored;
            assign rd_busy[gi]          = busy[addr];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb built with three read ports.
module tb_regfile_sb;

    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NRD = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              wb_en, wb_load, wb_pc, wb_alu;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     load_data, pc_data, alu_data;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .wb_en     (wb_en),
        .wb_load   (wb_load),
        .wb_pc     (wb_pc),
        .wb_alu    (wb_alu),
        .wb_addr   (wb_addr),
        .load_data (load_data),
        .pc_data   (pc_data),
        .alu_data  (alu_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; iss_en = 1'b0; iss_addr = '0;
        wb_en = 1'b0; wb_load = 1'b0; wb_pc = 1'b0; wb_alu = 1'b0; wb_addr = '0;
        load_data = '0; pc_data = '0; alu_data = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2);
        rd_addr = {a2, a1, a0};
        #1;
    endtask

    task automatic chk(input string tag, input logic [NRD*DW-1:0] obs,
                       input logic [NRD*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst = 1'b1;
        tick();
        tick();

        // Reset overrides a write to x0 and an issue in the same cycle
        wb_en = 1'b1; wb_addr = 5'd0; wb_alu = 1'b1; alu_data = 64'hDEAD;
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        set_rd(5'd0, 5'd5, 5'd3);
        chk("reset_cnt", {186'd0, busy_cnt}, {186'd0, 6'd0});
        chk("reset_rd", rd_data, '0);
        chk("reset_busy", {189'd0, rd_busy}, {189'd0, 3'b000});

        // Write to x0 outside reset is discarded
        wb_en = 1'b1; wb_addr = 5'd0; wb_alu = 1'b1; alu_data = 64'hDEAD;
        tick();
        idle();
        set_rd(5'd0, 5'd0, 5'd0);
        chk("x0_write", rd_data, '0);

        // Basic load writeback to x5
        wb_en = 1'b1; wb_addr = 5'd5; wb_load = 1'b1; load_data = 64'h1234_5678_9ABC_DEF0;
        set_rd(5'd5, 5'd0, 5'd0);
`ifdef RF_BYPASS_EN
        chk("wr_same_cycle", {128'd0, rd_data[63:0]}, {128'd0, 64'h1234_5678_9ABC_DEF0});
`else
        chk("wr_same_cycle", {128'd0, rd_data[63:0]}, {128'd0, 64'd0});
`endif
        tick();
        idle();
        #1;
        chk("wr_next_cycle", {128'd0, rd_data[63:0]}, {128'd0, 64'h1234_5678_9ABC_DEF0});
        chk("wr_nonbusy_cnt", {186'd0, busy_cnt}, {186'd0, 6'd0});

        // Scoreboard set/clear
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        chk("iss_x3_cnt", {186'd0, busy_cnt}, {186'd0, 6'd1});
        iss_addr = 5'd7;
        tick();
        chk("iss_x7_cnt", {186'd0, busy_cnt}, {186'd0, 6'd2});
        idle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_alu = 1'b1; alu_data = 64'h33;
        tick();
        idle();
        set_rd(5'd3, 5'd7, 5'd0);
        chk("wb_x3_cnt", {186'd0, busy_cnt}, {186'd0, 6'd1});
        chk("wb_x3_busy", {189'd0, rd_busy}, {189'd0, 3'b010});
        chk("wb_x3_data", {128'd0, rd_data[63:0]}, {128'd0, 64'h33});

        // Re-issue of an already-busy register leaves the count alone
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        idle();
        chk("reiss_x7_cnt", {186'd0, busy_cnt}, {186'd0, 6'd1});

        // Same-address collision on busy x9
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        chk("iss_x9_cnt", {186'd0, busy_cnt}, {186'd0, 6'd2});
        wb_en = 1'b1; wb_addr = 5'd9; wb_alu = 1'b1; alu_data = 64'h99;
        tick();
        idle();
        set_rd(5'd9, 5'd0, 5'd0);
        chk("coll_cnt", {186'd0, busy_cnt}, {186'd0, 6'd2});
        chk("coll_data", {128'd0, rd_data[63:0]}, {128'd0, 64'h99});
        chk("coll_busy", {189'd0, rd_busy}, {189'd0, 3'b001});

        // wb on busy x7 with iss on idle x10: net zero
        wb_en = 1'b1; wb_addr = 5'd7; wb_pc = 1'b1; pc_data = 64'h70;
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        idle();
        set_rd(5'd7, 5'd10, 5'd9);
        chk("net0_cnt", {186'd0, busy_cnt}, {186'd0, 6'd2});
        chk("net0_busy", {189'd0, rd_busy}, {189'd0, 3'b110});

        // Saturation then mid-run reset with a concurrent issue
        for (int r = 1; r < 32; r++) begin
            iss_en = 1'b1; iss_addr = AW'(r);
            tick();
        end
        idle();
        chk("sat_cnt", {186'd0, busy_cnt}, {186'd0, 6'd31});
        rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd2;
        tick();
        idle();
        set_rd(5'd2, 5'd31, 5'd5);
        chk("rst_mid_cnt", {186'd0, busy_cnt}, {186'd0, 6'd0});
        chk("rst_mid_busy", {189'd0, rd_busy}, {189'd0, 3'b000});
        chk("rst_mid_data", rd_data, '0);

        // Multi-port read including duplicate and x0
        wb_en = 1'b1; wb_addr = 5'd4; wb_alu = 1'b1; alu_data = 64'hA5;
        tick();
        idle();
        set_rd(5'd4, 5'd4, 5'd0);
        chk("mport", rd_data, {64'd0, 64'hA5, 64'hA5});

        // Non-one-hot select ORs the sources
        wb_en = 1'b1; wb_addr = 5'd4; wb_pc = 1'b1; wb_alu = 1'b1;
        pc_data = 64'hF0; alu_data = 64'h0F; load_data = 64'h100;
        tick();
        idle();
        #1;
        chk("sel_or", {128'd0, rd_data[63:0]}, {128'd0, 64'hFF});

        // Empty select writes zero
        wb_en = 1'b1; wb_addr = 5'd4; load_data = 64'h55; pc_data = 64'h66; alu_data = 64'h77;
        tick();
        idle();
        #1;
        chk("sel_none", {128'd0, rd_data[63:0]}, {128'd0, 64'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle GPR file, for the pipelined NPC core.
- Provides NRD combinational read ports and one writeback port with a three-source writeback select.
- Adds a per-register busy scoreboard: the issue stage sets a bit, writeback clears it.
- Adds a live count of outstanding writes so decode can stall on RAW hazards and drain before ecall or ebreak.

Parameters:
- DW, 64: data width.
- AW, 5: register address width; depth is 2**AW; register 0 is hard-wired zero.
- NRD, 2: number of read ports, minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- iss_en  in  1  issue stage claims a destination register.
- iss_addr  in  AW  destination register being claimed.
- wb_en  in  1  writeback valid.
- wb_load  in  1  select load_data.
- wb_pc  in  1  select pc_data.
- wb_alu  in  1  select alu_data.
- wb_addr  in  AW  writeback register.
- load_data  in  DW  data read from memory.
- pc_data  in  DW  pc+4.
- alu_data  in  DW  ALU result.
- rd_addr  in  NRD*AW  packed read addresses; port k is at [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data.
- rd_busy  out  NRD  per-port "operand not yet written".
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- When rst=1 at a rising edge:
  - all gpr entries go to 0;
  - all busy bits go to 0;
  - busy_cnt goes to 0.
  - Reset overrides any iss_en or wb_en in the same cycle.
  - Post-reset outputs: rd_data = 0 and rd_busy = 0 for every address.
- Writeback data: wb_data = OR of the selected sources (AND-OR mux).
  - Select bits are expected one-hot.
  - Non-one-hot selects OR the chosen sources; zero selects give 0. No error is flagged.
- Write: on a rising edge with wb_en=1 and wb_addr!=0, gpr[wb_addr] <= wb_data.
  - A write to x0 is discarded.
  - A write to a non-busy register is legal: the data is written and busy state is unchanged.
- Read: purely combinational, zero latency.
  - rd_data[k] = 0 if rd_addr[k]==0, otherwise gpr[rd_addr[k]].
  - Any port may read any address, including duplicates across ports.
- Scoreboard: busy[0] is constant 0. At each rising edge, in priority order:
  - clear busy[wb_addr] if wb_en=1;
  - then set busy[iss_addr] if iss_en=1 and iss_addr!=0;
  - so for the same address, set wins: a new producer replaces the old one.
- rd_busy[k] = busy[rd_addr[k]], for the no-bypass build.
- busy_cnt is a registered counter. Its next value equals the popcount of the next busy vector. Incremental rule:
  - +1 when a non-busy register becomes busy;
  - -1 when a busy register is cleared and not re-set;
  - unchanged when iss_en targets an already-busy register;
  - unchanged for simultaneous wb and iss on the same busy register;
  - net 0 for wb on register A and iss on register B when A is busy and B is idle.
- Range: busy_cnt reaches 2**AW - 1 when all non-zero registers are busy and never wraps. Width AW+1 is sufficient.
- Ordering: there is no negedge write. The pipeline relies on the bypass build or a one-cycle stall for same-cycle write-then-read.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when wb_en=1, wb_addr!=0 and rd_addr[k]==wb_addr:
  - rd_data[k] = wb_data in the same cycle;
  - rd_busy[k] = 0, unless iss_en=1 and iss_addr==wb_addr, in which case rd_busy[k] stays 1 because the register is being re-claimed.
- Undefined: reads return stored gpr contents; the written value is visible in the cycle after the edge. rd_busy reflects busy state only.
- busy_cnt and all storage are identical in both builds.

Decomposition:
- Shared package npc_pkg holds:
  - REG_AW = 5 and XLEN = 64 defaults;
  - the REG_ZERO address constant;
  - the wb-select one-hot bit positions: WB_LOAD = 0, WB_PC = 1, WB_ALU = 2.
- Sub-module rf_scoreboard owns the busy vector, busy_cnt and the set/clear priority logic, and is instantiated once.
- Storage, the wb mux, read ports and bypass stay in the top module.

Test Plan:
- Reset and zero register: assert rst, then wb_en=1, wb_addr=0, wb_alu=1, alu_data=0xDEAD -> rd_data for address 0 is 0, busy_cnt is 0, and all ports read 0 after reset.
- Basic write: wb_en=1, wb_addr=5, wb_load=1, load_data=0x1234_5678_9ABC_DEF0 -> next cycle, a read of address 5 returns that value. With RF_BYPASS_EN, the value appears in the same cycle.
- Scoreboard: iss x3, then iss x7 on the next cycle -> busy_cnt goes 1 then 2. wb to x3 -> busy_cnt = 1, rd_busy for x3 is 0 and for x7 is 1.
- Same-address collision: x9 busy; same cycle iss_en with iss_addr=9 and wb_en with wb_addr=9 -> x9 is written, stays busy, busy_cnt unchanged.
- Saturation and mid-run reset: issue x1 through x31 -> busy_cnt = 31. Assert rst with iss_en=1 -> busy_cnt = 0 and all rd_busy = 0 on the next cycle.
- Multi-port with NRD=3: ports read x4, x4, x0 while x4 holds 0xA5 -> rd_data = {0, 0xA5, 0xA5}. Select fault wb_pc=1 and wb_alu=1 with pc_data=0xF0 and alu_data=0x0F to x4 -> x4 reads 0xFF.
